// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the instruction loader and the debug unit that observes it.
// Holds the loader state encoding and the session framing constants.
package instruction_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_BYTE   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } loader_state_t;

    localparam int         HDR_LEN_BYTES  = 2;
    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] WE_ALL         = 4'b1111;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// Packs incoming bytes MSB first into an instruction word and flags the 4th byte.
// Latency: o_word/o_word_ready are combinational on the strobe that completes a word.
// Backpressure: none, every i_shift is consumed in the cycle it arrives.
module instruction_loader_word_assembler
    import instruction_loader_pkg::*;
#(
    parameter int NB_INSTR = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_clear,
    input  logic                i_shift,
    input  logic [7:0]          i_byte,
    output logic [NB_INSTR-1:0] o_word,
    output logic                o_word_ready
);
    localparam int         NB_HELD   = NB_INSTR - 8;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    // Only the first three bytes are stored; the 4th is taken straight from the input.
    logic [NB_HELD-1:0] held;
    logic [1:0]         byte_cnt;

    assign o_word       = {held, i_byte};
    assign o_word_ready = i_shift && (byte_cnt == LAST_BYTE);

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            held     <= '0;
            byte_cnt <= '0;
        end else if (i_clear) begin
            held     <= '0;
            byte_cnt <= '0;
        end else if (i_shift) begin
            held     <= (held << 8) | NB_HELD'(i_byte);
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into the instruction memory debug port.
// Latency: the word write happens the cycle after its 4th byte; o_done pulses the cycle after DONE.
// Backpressure: none, bytes are strobes; a strobe during WRITE becomes byte 0 of the next word.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int NB_INSTR = 32,
    parameter int N_ADDR   = 2048,
    parameter int NB_ADDR  = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [7:0]          i_rx_data,
    input  logic                i_rx_valid,
    input  logic                i_start,
    output logic [NB_ADDR-1:0]  o_instrmem_addr,
    output logic [NB_INSTR-1:0] o_instrmem_data,
    output logic [3:0]          o_instrmem_we,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_error
);
    localparam logic [31:0] ADDR_LIMIT = 32'(N_ADDR);

    loader_state_t       state;
    logic [7:0]          len_hi;
    logic [15:0]         n_words;
    logic [15:0]         word_idx;
    logic [15:0]         len_word;
    logic [16:0]         idx_next;
    logic                more_words;
    logic                asm_shift;
    logic                asm_clear;
    logic                word_ready;
    logic [NB_INSTR-1:0] asm_word;

    assign len_word   = {len_hi, i_rx_data};
    assign idx_next   = {1'b0, word_idx} + 17'd1;
    assign more_words = idx_next < {1'b0, n_words};
    assign asm_clear  = (state == ST_IDLE);
    assign asm_shift  = i_rx_valid && ((state == ST_BYTE) || (state == ST_WRITE && more_words));

    instruction_loader_word_assembler #(
        .NB_INSTR (NB_INSTR)
    ) u_word_assembler (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_clear      (asm_clear),
        .i_shift      (asm_shift),
        .i_byte       (i_rx_data),
        .o_word       (asm_word),
        .o_word_ready (word_ready)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state           <= ST_IDLE;
            len_hi          <= '0;
            n_words         <= '0;
            word_idx        <= '0;
            o_instrmem_addr <= '0;
            o_instrmem_data <= '0;
            o_instrmem_we   <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
        end else begin
            o_instrmem_we <= '0;
            o_done        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state    <= ST_LEN_HI;
                        o_busy   <= 1'b1;
                        o_error  <= 1'b0;
                        word_idx <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (i_rx_valid) begin
                        len_hi <= i_rx_data;
                        state  <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (i_rx_valid) begin
                        n_words <= len_word;
                        if (32'(len_word) > ADDR_LIMIT) begin
                            o_error <= 1'b1;
                        end
                        state <= (len_word == 16'd0) ? ST_DONE : ST_BYTE;
                    end
                end
                ST_BYTE: begin
                    if (word_ready) begin
                        state           <= ST_WRITE;
                        o_instrmem_data <= asm_word;
                        o_instrmem_addr <= NB_ADDR'(word_idx);
                        // Overflow words are still drained from the stream, just never written.
                        o_instrmem_we   <= (32'(word_idx) < ADDR_LIMIT) ? WE_ALL : 4'b0000;
                    end
                end
                ST_WRITE: begin
                    word_idx <= idx_next[15:0];
                    state    <= more_words ? ST_BYTE : ST_DONE;
                end
                ST_DONE: begin
                    o_done <= !o_error;
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Self-checking bench for instruction_loader, built with a 4-word memory so overflow is reachable.
module tb_instruction_loader;
    localparam int NB_INSTR = 32;
    localparam int N_ADDR   = 4;
    localparam int NB_ADDR  = 16;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b1;
    logic [7:0]          rx_data  = 8'h00;
    logic                rx_valid = 1'b0;
    logic                start    = 1'b0;
    logic [NB_ADDR-1:0]  addr;
    logic [NB_INSTR-1:0] data;
    logic [3:0]          we;
    logic                busy;
    logic                done;
    logic                error;

    instruction_loader #(
        .NB_INSTR (NB_INSTR),
        .N_ADDR   (N_ADDR),
        .NB_ADDR  (NB_ADDR)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_rx_data       (rx_data),
        .i_rx_valid      (rx_valid),
        .i_start         (start),
        .o_instrmem_addr (addr),
        .o_instrmem_data (data),
        .o_instrmem_we   (we),
        .o_busy          (busy),
        .o_done          (done),
        .o_error         (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [15:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];
    int          done_cyc_q[$];
    logic        done_busy_q[$];
    int          byte4_cyc_q[$];
    logic [31:0] sess_words[$];
    int          bad_we       = 0;
    int          err_rise_cyc = -1;
    int          lsb_cyc      = 0;
    logic        last_busy    = 1'b0;

    // Passive log of everything the DUT presents to the memory port.
    always @(negedge clk) begin
        if (we === 4'hF) begin
            wr_addr_q.push_back(addr);
            wr_data_q.push_back(data);
            wr_cyc_q.push_back(cyc);
        end else if (we !== 4'h0) begin
            bad_we++;
        end
        if (done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            done_busy_q.push_back(busy);
        end
        if (error === 1'b1 && err_rise_cyc < 0) err_rise_cyc = cyc;
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cyc_q.delete();
        done_busy_q.delete();
        byte4_cyc_q.delete();
        err_rise_cyc = -1;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic s);
        @(posedge clk);
        #1;
        rx_valid = v;
        rx_data  = d;
        start    = s;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input logic noise);
        repeat (gap) step(1'b0, 8'($urandom), 1'b0);
        step(1'b1, b, noise);
    endtask

    // Drives start, the 2-byte count and all words in sess_words (MSB first), with random gaps.
    task automatic run_session(input int n, input int gap_max, input logic noise);
        logic [31:0] w;
        step(1'b0, 8'h00, 1'b1);
        send_byte(8'(n >> 8), int'($urandom_range(gap_max, 0)), noise);
        send_byte(8'(n), int'($urandom_range(gap_max, 0)), noise);
        lsb_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            w = sess_words[i];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31 - 8*b -: 8], int'($urandom_range(gap_max, 0)), noise);
            end
            byte4_cyc_q.push_back(cyc);
        end
        @(negedge clk);
        last_busy = busy;
        step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b required 0 within 200 cycles", name, busy);
        end
        repeat (2) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (addr !== '0)  begin errors++; $display("FAIL reset_addr: got %h required 0", addr); end
        checks++; if (data !== '0)  begin errors++; $display("FAIL reset_data: got %h required 0", data); end
        checks++; if (we !== 4'h0)  begin errors++; $display("FAIL reset_we: got %h required 0", we); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", error); end
        rst_n = 1'b1;
        repeat (2) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_single();
        clear_logs();
        sess_words = '{32'h2008_0005};
        run_session(1, 0, 1'b0);
        wait_idle("single");
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL single_wr_count: got %0d required 1", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 1) begin
            checks++; if (wr_addr_q[0] !== 16'd0) begin errors++; $display("FAIL single_addr: got %h required 0", wr_addr_q[0]); end
            checks++; if (wr_data_q[0] !== 32'h2008_0005) begin errors++; $display("FAIL single_data: got %h required 20080005", wr_data_q[0]); end
            checks++; if (wr_cyc_q[0] != byte4_cyc_q[0] + 1) begin errors++; $display("FAIL single_wr_latency: got cycle %0d required %0d", wr_cyc_q[0], byte4_cyc_q[0] + 1); end
        end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL single_done_count: got %0d required 1", done_cyc_q.size()); end
        if (done_cyc_q.size() >= 1) begin
            checks++; if (done_cyc_q[0] != byte4_cyc_q[0] + 3) begin errors++; $display("FAIL single_done_cycle: got %0d required %0d", done_cyc_q[0], byte4_cyc_q[0] + 3); end
            checks++; if (done_busy_q[0] !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b required 0", done_busy_q[0]); end
        end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL single_error: got %b required 0", error); end
    endtask

    task automatic test_back_to_back();
        clear_logs();
        sess_words = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        run_session(3, 0, 1'b0);
        wait_idle("b2b");
        checks++; if (wr_addr_q.size() != 3) begin errors++; $display("FAIL b2b_wr_count: got %0d required 3", wr_addr_q.size()); end
        for (int i = 0; i < 3 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== 16'(i)) begin errors++; $display("FAIL b2b_addr[%0d]: got %h required %h", i, wr_addr_q[i], 16'(i)); end
            checks++; if (wr_data_q[i] !== sess_words[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h required %h", i, wr_data_q[i], sess_words[i]); end
            checks++; if (wr_cyc_q[i] != byte4_cyc_q[i] + 1) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d required %0d", i, wr_cyc_q[i], byte4_cyc_q[i] + 1); end
        end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL b2b_done_count: got %0d required 1", done_cyc_q.size()); end
    endtask

    task automatic test_zero_len();
        clear_logs();
        sess_words.delete();
        run_session(0, 0, 1'b0);
        wait_idle("zero");
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL zero_wr_count: got %0d required 0", wr_addr_q.size()); end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL zero_done_count: got %0d required 1", done_cyc_q.size()); end
        if (done_cyc_q.size() >= 1) begin
            checks++; if (done_cyc_q[0] != lsb_cyc + 2) begin errors++; $display("FAIL zero_done_cycle: got %0d required %0d", done_cyc_q[0], lsb_cyc + 2); end
        end
    endtask

    task automatic test_overflow();
        clear_logs();
        sess_words.delete();
        for (int i = 0; i < 5; i++) sess_words.push_back($urandom);
        run_session(5, 1, 1'b0);
        checks++; if (last_busy !== 1'b1) begin errors++; $display("FAIL ovf_busy_last_byte: got %b required 1", last_busy); end
        wait_idle("ovf");
        checks++; if (wr_addr_q.size() != N_ADDR) begin errors++; $display("FAIL ovf_wr_count: got %0d required %0d", wr_addr_q.size(), N_ADDR); end
        for (int i = 0; i < N_ADDR && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== 16'(i) || wr_data_q[i] !== sess_words[i]) begin
                errors++; $display("FAIL ovf_write[%0d]: got %h/%h required %h/%h", i, wr_addr_q[i], wr_data_q[i], 16'(i), sess_words[i]);
            end
        end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_error: got %b required 1", error); end
        checks++; if (err_rise_cyc != lsb_cyc + 1) begin errors++; $display("FAIL ovf_error_cycle: got %0d required %0d", err_rise_cyc, lsb_cyc + 1); end
        checks++; if (done_cyc_q.size() != 0) begin errors++; $display("FAIL ovf_no_done: got %0d pulses required 0", done_cyc_q.size()); end
        clear_logs();
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL ovf_error_clear: got %b required 0", error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ovf_restart_busy: got %b required 1", busy); end
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        wait_idle("ovf_restart");
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL ovf_restart_done: got %0d required 1", done_cyc_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        clear_logs();
        w = $urandom;
        step(1'b0, 8'h00, 1'b1);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h01, 0, 1'b0);
        send_byte(w[31:24], 0, 1'b0);
        send_byte(w[23:16], 0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
        checks++; if (data !== '0) begin errors++; $display("FAIL rstmid_data: got %h required 0", data); end
        checks++; if (addr !== '0 || we !== 4'h0) begin errors++; $display("FAIL rstmid_addr_we: got %h/%h required 0/0", addr, we); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL rstmid_no_write: got %0d writes required 0", wr_addr_q.size()); end
        sess_words = '{$urandom};
        run_session(1, 1, 1'b0);
        wait_idle("rstmid");
        checks++; if (wr_addr_q.size() != 1) begin errors++; $display("FAIL rstmid_fresh_count: got %0d required 1", wr_addr_q.size()); end
        if (wr_addr_q.size() >= 1) begin
            checks++; if (wr_addr_q[0] !== 16'd0 || wr_data_q[0] !== sess_words[0]) begin
                errors++; $display("FAIL rstmid_fresh_write: got %h/%h required 0/%h", wr_addr_q[0], wr_data_q[0], sess_words[0]);
            end
        end
    endtask

    task automatic test_ignored();
        clear_logs();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 0, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_busy: got %b required 0", busy); end
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL ign_idle_writes: got %0d required 0", wr_addr_q.size()); end
        sess_words = '{$urandom, $urandom};
        run_session(2, 1, 1'b1);
        wait_idle("ign");
        checks++; if (wr_addr_q.size() != 2) begin errors++; $display("FAIL ign_wr_count: got %0d required 2", wr_addr_q.size()); end
        for (int i = 0; i < 2 && i < wr_addr_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== 16'(i) || wr_data_q[i] !== sess_words[i]) begin
                errors++; $display("FAIL ign_write[%0d]: got %h/%h required %h/%h", i, wr_addr_q[i], wr_data_q[i], 16'(i), sess_words[i]);
            end
        end
        checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL ign_done_count: got %0d required 1", done_cyc_q.size()); end
    endtask

    task automatic test_random();
        int n;
        int exp_wr;
        for (int it = 0; it < 25; it++) begin
            n = int'($urandom_range(6, 0));
            exp_wr = (n < N_ADDR) ? n : N_ADDR;
            clear_logs();
            sess_words.delete();
            for (int i = 0; i < n; i++) sess_words.push_back($urandom);
            run_session(n, int'($urandom_range(2, 0)), 1'($urandom % 2));
            wait_idle("rand");
            checks++; if (wr_addr_q.size() != exp_wr) begin errors++; $display("FAIL rand%0d_wr_count: got %0d required %0d (n=%0d)", it, wr_addr_q.size(), exp_wr, n); end
            for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
                checks++; if (wr_addr_q[i] !== 16'(i) || wr_data_q[i] !== sess_words[i] || wr_cyc_q[i] != byte4_cyc_q[i] + 1) begin
                    errors++; $display("FAIL rand%0d_write[%0d]: got %h/%h@%0d required %h/%h@%0d", it, i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], 16'(i), sess_words[i], byte4_cyc_q[i] + 1);
                end
            end
            checks++; if (done_cyc_q.size() != ((n <= N_ADDR) ? 1 : 0)) begin errors++; $display("FAIL rand%0d_done: got %0d pulses required %0d", it, done_cyc_q.size(), (n <= N_ADDR) ? 1 : 0); end
            checks++; if (error !== (n > N_ADDR)) begin errors++; $display("FAIL rand%0d_error: got %b required %b", it, error, n > N_ADDR); end
        end
        checks++; if (bad_we != 0) begin errors++; $display("FAIL we_encoding: got %0d partial-enable cycles required 0", bad_we); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_zero_len();
        test_overflow();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter NB_INSTR, default 32, instruction word width.
REQ-002 Parameter N_ADDR, default 2048, instruction memory depth in words.
REQ-003 Parameter NB_ADDR, default 16, width of the memory debug address port.
REQ-004 Port i_clock  in  1  single system clock; all flops rising-edge.
REQ-005 Port i_reset  in  1  reset, asynchronous, active-low.
REQ-006 Port i_rx_data  in  8  received byte from the serial receiver.
REQ-007 Port i_rx_valid  in  1  one-cycle strobe qualifying i_rx_data.
REQ-008 Port i_start  in  1  one-cycle request to begin a load session.
REQ-009 Port o_instrmem_addr  out  NB_ADDR  word address into the instruction memory debug port.
REQ-010 Port o_instrmem_data  out  NB_INSTR  assembled instruction word.
REQ-011 Port o_instrmem_we  out  4  byte write enables to the instruction memory debug port.
REQ-012 Port o_busy  out  1  high while a session is active; the CPU pipeline valid is gated with it.
REQ-013 Port o_done  out  1  one-cycle pulse when a session completes without error.
REQ-014 Port o_error  out  1  sticky flag for a length overflow; cleared by the next i_start.

Function
REQ-015 Session byte stream SHALL be: count MSB, count LSB (N words), then 4*N instruction bytes, each word MSB first.
REQ-016 FSM states SHALL be IDLE, LEN_HI, LEN_LO, BYTE, WRITE, DONE.
REQ-017 IDLE SHALL go to LEN_HI on i_start; i_rx_valid in IDLE SHALL be ignored.
REQ-018 LEN_HI→LEN_LO and LEN_LO→BYTE SHALL each advance only on i_rx_valid; LEN_LO with N==0 SHALL go directly to DONE.
REQ-019 BYTE SHALL shift i_rx_data into a NB_INSTR shift register on each i_rx_valid and count bytes 0..3; the 4th byte SHALL move to WRITE.
REQ-020 WRITE SHALL last exactly one cycle: o_instrmem_we=4'b1111, o_instrmem_data=assembled word, o_instrmem_addr=word index; o_instrmem_we SHALL be 0 in every other cycle.
REQ-021 After WRITE, word index SHALL increment; BYTE SHALL resume if index<N, else go to DONE.
REQ-022 A byte strobe arriving in the WRITE cycle SHALL be captured as byte 0 of the next word, never lost.
REQ-023 DONE SHALL assert o_done for one cycle (unless o_error) and return to IDLE.
REQ-024 If N>N_ADDR, o_error SHALL set in LEN_LO; words with index>=N_ADDR SHALL be consumed but not written (we=0); the session SHALL still consume all 4*N bytes.
REQ-025 o_busy SHALL be high in every state except IDLE and SHALL drop the cycle after DONE.
REQ-026 i_start while busy SHALL be ignored.
REQ-027 Word index SHALL be 16 bits, with no wrap within a session; o_instrmem_addr SHALL be the index zero-extended/truncated to NB_ADDR.
REQ-028 Latency: WRITE SHALL occur on the cycle after the 4th byte strobe of each word.

Reset
REQ-029 On i_reset low, asynchronously: state=IDLE, o_instrmem_addr=0, o_instrmem_data=0, o_instrmem_we=0, o_busy=0, o_done=0, o_error=0, counters=0.
REQ-030 Reset mid-session SHALL abort without any further write; partially assembled words SHALL be discarded.

Structure
REQ-031 The FSM state encoding and the header length (2 bytes) SHALL live in a shared package used by the debug unit.
REQ-032 One sub-module is natural: word_assembler (byte shift register plus 0..3 byte counter, word_ready output).

Verification
REQ-033 Start, bytes 00 01 20 08 00 05 -> one write at addr 0, data 0x20080005, we=F; o_done pulses; o_busy then low.
REQ-034 Start, N=3 with words 0x11111111, 0x22222222, 0x33333333, strobes back-to-back every cycle -> writes at addr 0,1,2 with correct data, none dropped.
REQ-035 Start, bytes 00 00 -> no write, o_done pulse two cycles after the LSB.
REQ-036 N_ADDR=4, N=5 -> o_error set after LEN_LO; writes at 0..3 only; 20 bytes consumed; no o_done; o_error clears on the next i_start.
REQ-037 Reset asserted after 2 of 4 data bytes -> no write, all outputs 0; a fresh session then writes at addr 0.
REQ-038 Bytes sent while IDLE, and i_start pulses while busy -> ignored; session data unaffected.
